// File: rtl/pl_pkg.sv
// Shared pipeline definitions: occupancy states, stage bundle layouts and widths,
// and the occupancy transition function used by the pipeline stage registers.
package pl_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } pl_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } pl_if_id_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [3:0]  alu_op;
        logic        mem_rd;
        logic        mem_wr;
        logic        reg_wr;
    } pl_id_ex_t;

    typedef struct packed {
        logic [31:0] alu_res;
        logic [31:0] store_data;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic        mem_rd;
        logic        mem_wr;
        logic        reg_wr;
    } pl_ex_mem_t;

    typedef struct packed {
        logic [31:0] wb_data;
        logic [4:0]  rd;
        logic        reg_wr;
    } pl_mem_wb_t;

    localparam int unsigned PL_IF_W = $bits(pl_if_id_t);
    localparam int unsigned PL_IE_W = $bits(pl_id_ex_t);
    localparam int unsigned PL_EM_W = $bits(pl_ex_mem_t);
    localparam int unsigned PL_MW_W = $bits(pl_mem_wb_t);

    // Occupancy transition ignoring flush; SKID never accepts because s_ready=0 there.
    function automatic pl_state_t pl_next_state(input pl_state_t st,
                                                input logic acc,
                                                input logic drn);
        pl_state_t nxt;
        nxt = st;
        case (st)
            EMPTY: if (acc) nxt = FULL;
            FULL: begin
                if (acc && !drn)      nxt = SKID;
                else if (!acc && drn) nxt = EMPTY;
            end
            SKID:  if (drn) nxt = FULL;
            default: nxt = EMPTY;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/pl_reg_skid.sv
// Flushable valid/ready pipeline register with a one-entry skid buffer.
// Optional downstream-stall counter on stall_cnt when PL_REG_SKID_PERF_EN is defined.
module pl_reg_skid
    import pl_pkg::*;
#(
    parameter int unsigned          DATA_W   = 32,
    parameter logic [DATA_W-1:0]    RST_DATA = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data
`ifdef PL_REG_SKID_PERF_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    pl_state_t         r_state;
    logic              r_main_v;
    logic              r_s_ready;
    logic [DATA_W-1:0] r_main_q;
    logic [DATA_W-1:0] r_skid_q;

    logic              w_acc;
    logic              w_drn;
    pl_state_t         w_state_nxt;

    assign w_acc       = s_valid & r_s_ready;
    assign w_drn       = r_main_v & m_ready;
    assign w_state_nxt = pl_next_state(r_state, w_acc, w_drn);

    assign s_ready = r_s_ready;
    assign m_valid = r_main_v;
    assign m_data  = r_main_q;

    // Valid and ready flags are recomputed from the next state so both stay registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= EMPTY;
            r_main_v  <= 1'b0;
            r_s_ready <= 1'b1;
            r_main_q  <= RST_DATA;
            r_skid_q  <= RST_DATA;
        end else if (flush) begin
            r_state   <= EMPTY;
            r_main_v  <= 1'b0;
            r_s_ready <= 1'b1;
            r_main_q  <= RST_DATA;
            r_skid_q  <= RST_DATA;
        end else begin
            case (r_state)
                EMPTY: if (w_acc) r_main_q <= s_data;
                FULL: begin
                    if (w_acc && w_drn)       r_main_q <= s_data;
                    else if (w_acc && !w_drn) r_skid_q <= s_data;
                end
                SKID:  if (w_drn) r_main_q <= r_skid_q;
                default: ;
            endcase
            r_state   <= w_state_nxt;
            r_main_v  <= (w_state_nxt != EMPTY);
            r_s_ready <= (w_state_nxt != SKID);
        end
    end

`ifdef PL_REG_SKID_PERF_EN
    logic [31:0] r_stall_cnt;

    // Flush does not clear the counter; it counts the stalled cycle it lands on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (r_main_v && !m_ready && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
